// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, opcodes,
// FSM state encoding and the captured-instruction buffer layout.
package fetch_pkg;

    localparam int PC_W   = 16;
    localparam int I_SIZE = 32;

    localparam logic [6:0] OPC_JMP = 7'h0e;
    localparam logic [6:0] OPC_JAL = 7'h0f;

    // ST_START is the post-reset entry cycle in which no request is driven yet.
    localparam logic [1:0] ST_START   = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    typedef struct packed {
        logic [15:0]     imm;
        logic [15:0]     instr_l;
        logic            pred;
        logic [PC_W-1:0] next_pc;
    } fetch_buf_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_pred.sv
// Static branch predictor: JAL and unconditional JMP are predicted taken
// to the immediate, everything else falls through to pc+1.
module fetch_pred
    import fetch_pkg::*;
(
    input  logic [I_SIZE-1:0] instr,
    input  logic [PC_W-1:0]   pc,
    output logic              pred,
    output logic [PC_W-1:0]   next_pc
);

    logic [6:0] opcode;
    logic [3:0] cond;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign cond        = instr[10:7];
    assign unused_bits = ^instr[15:11];

    always_comb begin
        pred    = (opcode == OPC_JAL) || ((opcode == OPC_JMP) && (cond == 4'h0));
        next_pc = pred ? instr[31:16] : pc_inc(pc);
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding memory request, a single
// instruction buffer towards decode, and flush/redirect handling.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_mem_req,
    output logic [PC_W-1:0]   o_mem_addr,
    input  logic [I_SIZE-1:0] i_mem_data,
    input  logic              i_mem_ack,
    output logic [15:0]       o_instr_l,
    output logic [15:0]       o_imm,
    output logic              o_jmp_pred,
    output logic              o_submit,
    input  logic              i_next_ready,
    input  logic              i_flush,
    input  logic [PC_W-1:0]   i_flush_pc,
    output logic [1:0]        o_dbg_state
);

    // Handshakes: o_mem_req stays high with a stable o_mem_addr until the
    // cycle i_mem_ack is sampled; decode acceptance is i_next_ready sampled
    // while an instruction is buffered, answered by a one-cycle o_submit.

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    fetch_buf_t      hold_q;
    logic            capture;
    logic            submit;
    logic            pred;
    logic [PC_W-1:0] pred_pc;

    fetch_pred u_pred (
        .instr   (i_mem_data),
        .pc      (pc_q),
        .pred    (pred),
        .next_pc (pred_pc)
    );

    // addr_q is the address of the request on the bus; it diverges from
    // pc_q only while a stale request is being drained in ST_DISCARD.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        capture = 1'b0;
        submit  = 1'b0;
        case (state_q)
            ST_START: begin
                state_d = ST_REQ;
                if (i_flush) begin
                    pc_d   = i_flush_pc;
                    addr_d = i_flush_pc;
                end
            end
            ST_REQ: begin
                if (i_flush) begin
                    pc_d = i_flush_pc;
                    if (i_mem_ack) begin
                        addr_d = i_flush_pc;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end else if (i_mem_ack) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_flush) begin
                    pc_d    = i_flush_pc;
                    addr_d  = i_flush_pc;
                    state_d = ST_REQ;
                end else if (i_next_ready) begin
                    submit  = 1'b1;
                    pc_d    = hold_q.next_pc;
                    addr_d  = hold_q.next_pc;
                    state_d = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (i_flush) begin
                    pc_d = i_flush_pc;
                end
                if (i_mem_ack) begin
                    addr_d  = pc_d;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_START;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= '{imm: i_mem_data[31:16], instr_l: i_mem_data[15:0],
                        pred: pred, next_pc: pred_pc};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_submit   <= 1'b0;
            o_instr_l  <= '0;
            o_imm      <= '0;
            o_jmp_pred <= 1'b0;
        end else begin
            o_submit <= submit;
            if (submit) begin
                o_instr_l  <= hold_q.instr_l;
                o_imm      <= hold_q.imm;
                o_jmp_pred <= hold_q.pred;
            end
        end
    end

    assign o_mem_req   = (state_q == ST_REQ) || (state_q == ST_DISCARD);
    assign o_mem_addr  = addr_q;
    assign o_dbg_state = state_q;

endmodule
